// File: rtl/hydra_ingress_framer.sv
`default_nettype none
// ============================================================================
// Module   : hydra_ingress_framer
// Purpose  : Per-port ingress framer. It turns a descriptor and a payload stream
//            into the hydra write protocol (sop/header, payload words, eop).
// Options  : FRAMER_TIMEOUT_EN enables the stalled-payload timeout and zero padding.
// Revision : 1.0 - initial release
// ============================================================================
module hydra_ingress_framer #(
    parameter int MAX_LEN = 256,
    parameter int MIN_GAP = 0,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        desc_vld,
    output logic        desc_rdy,
    input  logic [3:0]  desc_dest,
    input  logic [2:0]  desc_prio,
    input  logic [8:0]  desc_len,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic [15:0] in_data,
    input  logic        pause,
    output logic        wr_sop,
    output logic        wr_eop,
    output logic        wr_vld,
    output logic [15:0] wr_data,
    output logic        busy,
    output logic        len_err,
    output logic [15:0] pkt_cnt,
    output logic        pad_flag
);

    localparam logic [1:0]  c_idle     = 2'd0;
    localparam logic [1:0]  c_sop      = 2'd1;
    localparam logic [1:0]  c_pay      = 2'd2;
    localparam logic [1:0]  c_eop      = 2'd3;
    localparam logic [8:0]  c_max_len  = 9'(MAX_LEN);
    localparam logic [15:0] c_min_gap  = 16'(MIN_GAP);
    localparam logic        c_gapless  = (MIN_GAP == 0);

    logic [1:0]  r_state;
    logic [15:0] r_gap;
    logic [8:0]  r_rem;
    logic [15:0] r_hdr;
    logic        w_pad;
    logic        w_xfer;
    logic        w_len_bad;

    // A gapless framer can take the next descriptor during the eop cycle itself.
    assign desc_rdy  = !rst && (((r_state == c_idle) && (r_gap == '0)) ||
                                ((r_state == c_eop) && c_gapless));
    assign in_rdy    = !rst && (r_state == c_pay) && (r_rem != '0) && !pause && !w_pad;
    assign w_xfer    = in_vld && in_rdy;
    assign w_len_bad = (desc_len == '0) || (desc_len > c_max_len);
    assign busy      = (r_state != c_idle);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_gap   <= '0;
            r_rem   <= '0;
            r_hdr   <= '0;
            wr_sop  <= 1'b0;
            wr_eop  <= 1'b0;
            wr_vld  <= 1'b0;
            wr_data <= '0;
            len_err <= 1'b0;
            pkt_cnt <= '0;
        end else begin
            wr_sop  <= 1'b0;
            wr_eop  <= 1'b0;
            len_err <= 1'b0;
            case (r_state)
                c_idle: begin
                    wr_vld <= 1'b0;
                    if (r_gap != '0) begin
                        r_gap <= r_gap - 16'd1;
                    end
                end
                c_sop: begin
                    if (!pause) begin
                        wr_vld  <= 1'b1;
                        wr_data <= r_hdr;
                        r_rem   <= r_hdr[15:7];
                        r_state <= c_pay;
                    end else begin
                        wr_vld <= 1'b0;
                    end
                end
                c_pay: begin
                    if (r_rem == '0) begin
                        wr_vld  <= 1'b0;
                        wr_eop  <= 1'b1;
                        r_state <= c_eop;
                    end else if (w_xfer) begin
                        wr_vld  <= 1'b1;
                        wr_data <= in_data;
                        r_rem   <= r_rem - 9'd1;
                    end else if (w_pad && !pause) begin
                        wr_vld  <= 1'b1;
                        wr_data <= '0;
                        r_rem   <= r_rem - 9'd1;
                    end else begin
                        wr_vld <= 1'b0;
                    end
                end
                default: begin
                    wr_vld  <= 1'b0;
                    pkt_cnt <= pkt_cnt + 16'd1;
                    r_gap   <= c_min_gap;
                    r_state <= c_idle;
                end
            endcase
            // Acceptance overrides the state update above; desc_rdy is only high in IDLE/EOP.
            if (desc_vld && desc_rdy) begin
                if (w_len_bad) begin
                    len_err <= 1'b1;
                end else begin
                    r_hdr   <= {desc_len, desc_prio, desc_dest};
                    wr_sop  <= 1'b1;
                    r_state <= c_sop;
                end
            end
        end
    end

`ifdef FRAMER_TIMEOUT_EN
    localparam logic [15:0] c_timeout_m1 = 16'(TIMEOUT - 1);

    logic [15:0] r_to_cnt;
    logic        r_pad;
    logic        r_pad_flag;

    // Only pause-free edges without a transfer count towards the stall limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt   <= '0;
            r_pad      <= 1'b0;
            r_pad_flag <= 1'b0;
        end else if (r_state != c_pay) begin
            r_to_cnt <= '0;
            r_pad    <= 1'b0;
        end else if (w_xfer) begin
            r_to_cnt <= '0;
        end else if (!pause && (r_rem != '0) && !r_pad) begin
            if (r_to_cnt == c_timeout_m1) begin
                r_to_cnt   <= '0;
                r_pad      <= 1'b1;
                r_pad_flag <= 1'b1;
            end else begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end
        end
    end

    assign w_pad    = r_pad;
    assign pad_flag = r_pad_flag;
`else
    assign w_pad    = 1'b0;
    assign pad_flag = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hydra_ingress_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hydra_ingress_framer
// Purpose  : Scoreboard bench for hydra_ingress_framer (expected words queued at handshake).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hydra_ingress_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        desc_vld = 1'b0;
    logic        desc_rdy;
    logic [3:0]  desc_dest = '0;
    logic [2:0]  desc_prio = '0;
    logic [8:0]  desc_len = '0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [15:0] in_data = '0;
    logic        pause = 1'b0;
    logic        wr_sop, wr_eop, wr_vld, busy, len_err, pad_flag;
    logic [15:0] wr_data, pkt_cnt;

    hydra_ingress_framer #(.MAX_LEN(256), .MIN_GAP(0), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .desc_vld(desc_vld), .desc_rdy(desc_rdy),
        .desc_dest(desc_dest), .desc_prio(desc_prio), .desc_len(desc_len),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .pause(pause),
        .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld), .wr_data(wr_data),
        .busy(busy), .len_err(len_err), .pkt_cnt(pkt_cnt), .pad_flag(pad_flag)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] sb[$];
    logic [15:0] mon_exp;
    int sop_cnt = 0, eop_cnt = 0, vld_cnt = 0, last_sop_cyc = -1, last_eop_cyc = -1;

    logic [15:0] src_next = 16'd1;
    int          src_sent = 0;
    int          src_limit = 0;
    bit          src_on = 1'b0;

    // Output monitor: protocol exclusivity plus in-order scoreboard of every wr_vld word.
    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            if ($countones({wr_sop, wr_vld, wr_eop}) > 1) begin
                fails++;
                $display("FAIL exclusive @%0d: sop/vld/eop=%b required at most one high", cyc, {wr_sop, wr_vld, wr_eop});
            end
            if (wr_sop) begin sop_cnt++; last_sop_cyc = cyc; end
            if (wr_eop) begin eop_cnt++; last_eop_cyc = cyc; end
            if (wr_vld) begin
                vld_cnt++;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL sb_empty @%0d: wr_data=%h but no word expected", cyc, wr_data);
                end else begin
                    mon_exp = sb.pop_front();
                    if (wr_data !== mon_exp) begin
                        fails++;
                        $display("FAIL sb_word @%0d: wr_data=%h required %h", cyc, wr_data, mon_exp);
                    end
                end
            end
        end
    end

    // Payload source: offers consecutive words; accepted ones go into the scoreboard.
    always @(negedge clk) begin
        in_vld  = src_on && (src_sent < src_limit);
        in_data = src_next;
        #1;
        if (in_vld && in_rdy) begin
            sb.push_back(in_data);
            src_next = src_next + 16'd1;
            src_sent++;
        end
    end

    task automatic start_src(input int n);
        src_next  = 16'd1;
        src_sent  = 0;
        src_limit = n;
        src_on    = 1'b1;
    endtask

    // Presents one descriptor until accepted; k is the cycle in which wr_sop should show.
    task automatic send_desc(input logic [3:0] d, input logic [2:0] p, input logic [8:0] l,
                             input bit legal, input logic [15:0] hdr, output int k);
        bit done = 1'b0;
        k = -1;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            desc_dest = d; desc_prio = p; desc_len = l; desc_vld = 1'b1;
            #1;
            if (desc_rdy) begin
                done = 1'b1;
                if (legal) sb.push_back(hdr);
            end
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL desc_accept: desc_rdy=0 after 500 cycles required 1");
        end
        @(posedge clk);
        #1;
        k = cyc;
        desc_vld = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #2;
        tests++;
        if ({wr_sop, wr_vld, wr_eop, busy, len_err, pad_flag, desc_rdy, in_rdy, wr_data, pkt_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got sop%b vld%b eop%b busy%b err%b pad%b drdy%b irdy%b data%h cnt%h required all 0",
                     wr_sop, wr_vld, wr_eop, busy, len_err, pad_flag, desc_rdy, in_rdy, wr_data, pkt_cnt);
        end
        rst = 1'b0;
        @(negedge clk); #2;
        tests++;
        if (desc_rdy !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: desc_rdy=%b busy=%b required 1 0", desc_rdy, busy);
        end
    endtask

    task automatic test_basic();
        int k, e0, v0;
        e0 = eop_cnt; v0 = vld_cnt;
        start_src(42);
        send_desc(4'd3, 3'd4, 9'd42, 1'b1, 16'h1543, k);
        @(negedge clk); #2;
        tests++;
        if (wr_sop !== 1'b1 || in_rdy !== 1'b0) begin
            fails++;
            $display("FAIL basic_sop: wr_sop=%b in_rdy=%b required 1 0", wr_sop, in_rdy);
        end
        @(negedge clk); #2;
        tests++;
        if (wr_vld !== 1'b1 || wr_data !== 16'h1543) begin
            fails++;
            $display("FAIL basic_header: vld=%b data=%h required 1 1543", wr_vld, wr_data);
        end
        for (int i = 0; i < 200 && eop_cnt == e0; i++) begin @(negedge clk); #2; end
        tests++;
        if (last_eop_cyc !== k + 44) begin
            fails++;
            $display("FAIL basic_eop_time: eop at %0d required %0d", last_eop_cyc, k + 44);
        end
        tests++;
        if (vld_cnt - v0 !== 43) begin
            fails++;
            $display("FAIL basic_vld_count: %0d required 43", vld_cnt - v0);
        end
        @(negedge clk); #2;
        tests++;
        if (pkt_cnt !== 16'd1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_pkt_cnt: pkt_cnt=%0d busy=%b required 1 0", pkt_cnt, busy);
        end
        src_on = 1'b0;
    endtask

    task automatic test_back_to_back();
        int ka, kb, e0, v0, s0;
        e0 = eop_cnt; v0 = vld_cnt; s0 = sop_cnt;
        start_src(128);
        send_desc(4'd4, 3'd4, 9'd64, 1'b1, 16'h2044, ka);
        send_desc(4'd5, 3'd4, 9'd64, 1'b1, 16'h2045, kb);
        tests++;
        if (last_eop_cyc !== kb - 1 || last_eop_cyc !== ka + 66) begin
            fails++;
            $display("FAIL b2b_sop_after_eop: first eop %0d second sop %0d required eop %0d sop %0d",
                     last_eop_cyc, kb, ka + 66, ka + 67);
        end
        for (int i = 0; i < 300 && eop_cnt < e0 + 2; i++) begin @(negedge clk); #2; end
        @(negedge clk); #2;
        tests++;
        if (sop_cnt - s0 !== 2 || vld_cnt - v0 !== 130) begin
            fails++;
            $display("FAIL b2b_counts: sops %0d vlds %0d required 2 130", sop_cnt - s0, vld_cnt - v0);
        end
        tests++;
        if (pkt_cnt !== 16'd3 || last_eop_cyc !== kb + 66) begin
            fails++;
            $display("FAIL b2b_end: pkt_cnt=%0d eop at %0d required 3 at %0d", pkt_cnt, last_eop_cyc, kb + 66);
        end
        src_on = 1'b0;
    endtask

    task automatic test_pause();
        int k, e0;
        e0 = eop_cnt;
        start_src(42);
        send_desc(4'd3, 3'd4, 9'd42, 1'b1, 16'h1543, k);
        for (int i = 0; i < 200 && eop_cnt == e0; i++) begin
            @(negedge clk);
            if (cyc == k + 12) pause = 1'b1;
            if (cyc == k + 17) pause = 1'b0;
            #2;
            if (cyc == k + 12 || cyc == k + 18) begin
                tests++;
                if (wr_vld !== 1'b1 || wr_data !== ((cyc == k + 12) ? 16'd11 : 16'd12)) begin
                    fails++;
                    $display("FAIL pause_edge_word @%0d: vld=%b data=%h", cyc, wr_vld, wr_data);
                end
            end
            if (cyc >= k + 13 && cyc <= k + 17) begin
                tests++;
                if (wr_vld !== 1'b0) begin
                    fails++;
                    $display("FAIL pause_bubble @%0d: wr_vld=%b required 0", cyc, wr_vld);
                end
            end
        end
        tests++;
        if (last_eop_cyc !== k + 49) begin
            fails++;
            $display("FAIL pause_eop_time: eop at %0d required %0d", last_eop_cyc, k + 49);
        end
        src_on = 1'b0;
    endtask

    task automatic test_len_err();
        int k, s0, e0;
        logic [8:0] bad [2];
        bad[0] = 9'd0;
        bad[1] = 9'd257;
        for (int b = 0; b < 2; b++) begin
            s0 = sop_cnt;
            send_desc(4'd7, 3'd1, bad[b], 1'b0, 16'h0000, k);
            @(negedge clk); #2;
            tests++;
            if (len_err !== 1'b1 || wr_sop !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL len_err_pulse len=%0d: err=%b sop=%b busy=%b required 1 0 0", bad[b], len_err, wr_sop, busy);
            end
            @(negedge clk); #2;
            tests++;
            if (len_err !== 1'b0 || busy !== 1'b0 || sop_cnt !== s0) begin
                fails++;
                $display("FAIL len_err_after len=%0d: err=%b busy=%b sops=%0d required 0 0 %0d", bad[b], len_err, busy, sop_cnt, s0);
            end
        end
        e0 = eop_cnt;
        start_src(3);
        send_desc(4'd1, 3'd2, 9'd3, 1'b1, {9'd3, 3'd2, 4'd1}, k);
        for (int i = 0; i < 50 && eop_cnt == e0; i++) begin @(negedge clk); #2; end
        @(negedge clk); #2;
        tests++;
        if (pkt_cnt !== 16'd5 || last_eop_cyc !== k + 5) begin
            fails++;
            $display("FAIL len_err_recover: pkt_cnt=%0d eop at %0d required 5 at %0d", pkt_cnt, last_eop_cyc, k + 5);
        end
        src_on = 1'b0;
    endtask

    task automatic test_reset_mid();
        int k, e0;
        start_src(42);
        send_desc(4'd3, 3'd4, 9'd42, 1'b1, 16'h1543, k);
        for (int i = 0; i < 100 && cyc < k + 21; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #2;
        tests++;
        if ({wr_sop, wr_vld, wr_eop, busy, len_err, pad_flag, desc_rdy, in_rdy, wr_data, pkt_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: sop%b vld%b eop%b busy%b err%b pad%b drdy%b irdy%b data%h cnt%h required all 0",
                     wr_sop, wr_vld, wr_eop, busy, len_err, pad_flag, desc_rdy, in_rdy, wr_data, pkt_cnt);
        end
        rst = 1'b0;
        src_on = 1'b0;
        sb.delete();
        e0 = eop_cnt;
        @(negedge clk); #2;
        tests++;
        if (desc_rdy !== 1'b1 || pkt_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_mid_idle: desc_rdy=%b pkt_cnt=%0d required 1 0", desc_rdy, pkt_cnt);
        end
        repeat (30) @(negedge clk);
        #2;
        tests++;
        if (eop_cnt !== e0) begin
            fails++;
            $display("FAIL reset_mid_no_eop: %0d eops after reset required 0", eop_cnt - e0);
        end
    endtask

`ifdef FRAMER_TIMEOUT_EN
    task automatic test_timeout();
        int k, e0, v0;
        e0 = eop_cnt; v0 = vld_cnt;
        start_src(5);
        send_desc(4'd2, 3'd1, 9'd16, 1'b1, {9'd16, 3'd1, 4'd2}, k);
        for (int i = 0; i < 100 && src_sent < 5; i++) begin @(negedge clk); #2; end
        for (int i = 0; i < 11; i++) sb.push_back(16'h0000);
        for (int i = 0; i < 300 && eop_cnt == e0; i++) begin @(negedge clk); #2; end
        tests++;
        if (pad_flag !== 1'b1 || vld_cnt - v0 !== 17 || eop_cnt !== e0 + 1) begin
            fails++;
            $display("FAIL timeout_pad: pad_flag=%b vlds=%0d eops=%0d required 1 17 1", pad_flag, vld_cnt - v0, eop_cnt - e0);
        end
        src_on = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_pause();
        test_len_err();
        test_reset_mid();
`ifdef FRAMER_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: %0d words never emitted required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hydra_ingress_framer.md
Name: hydra_ingress_framer

Overview:
- Per-port ingress framer sitting directly upstream of one hydra write port.
- Takes a packet descriptor (dest, prio, length) plus a valid/ready payload stream.
- Emits the hydra write protocol on wr_sop/wr_vld/wr_data/wr_eop, honouring hydra's pause backpressure.
- Sixteen instances feed the 16 hydra write ports.

Parameters:
- MAX_LEN, 256: largest legal payload length in words; legal range is 1..MAX_LEN, and MAX_LEN ≤ 511.
- MIN_GAP, 0: idle cycles forced after a wr_eop cycle before the next descriptor is accepted.
- TIMEOUT, 64: stall limit in cycles. Used only with FRAMER_TIMEOUT_EN.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- desc_vld  in  1  descriptor valid.
- desc_rdy  out  1  descriptor ready (combinational).
- desc_dest  in  4  destination port.
- desc_prio  in  3  priority.
- desc_len  in  9  payload word count.
- in_vld  in  1  payload word valid.
- in_rdy  out  1  payload word ready (combinational).
- in_data  in  16  payload word.
- pause  in  1  backpressure from hydra.
- wr_sop  out  1  to hydra.
- wr_eop  out  1  to hydra.
- wr_vld  out  1  to hydra.
- wr_data  out  16  to hydra.
- busy  out  1  high whenever state ≠ IDLE.
- len_err  out  1  one-cycle pulse when a descriptor is rejected.
- pkt_cnt  out  16  packets completed; wraps 0xFFFF→0.
- pad_flag  out  1  sticky timeout-pad indicator; cleared by rst.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Registered outputs: wr_* are registers. The value driven in cycle n+1 is decided at edge n from state, pause, and in_vld.
- Reset: all outputs are 0 on the cycle after the rst edge; state goes to IDLE and the gap counter clears.
- Reset mid-packet: the packet is abandoned and no wr_eop is emitted. hydra is reset alongside.
- Header word: {len[8:0], prio[2:0], dest[3:0]}.

State machine:
- IDLE:
  - desc_rdy = 1 when the gap counter is 0.
  - On desc_vld && desc_rdy: latch the descriptor.
  - If desc_len is 0 or greater than MAX_LEN: pulse len_err next cycle, stay IDLE, emit nothing.
  - Otherwise: wr_sop=1 next cycle, go to SOP.
- SOP:
  - wr_sop is high for exactly one cycle.
  - At each edge with pause=0: drive the header (wr_vld=1), load rem=len, go to PAY.
  - While pause=1: wr_sop=0, wr_vld=0, remain in header-pending.
- PAY:
  - in_rdy = (rem≠0) && !pause.
  - On an edge with in_vld && in_rdy: next cycle wr_vld=1, wr_data=in_data, rem decrements.
  - Otherwise: wr_vld=0 (bubble), and wr_data holds its last value.
  - When rem reaches 0: the next cycle is wr_eop=1, wr_vld=0 (EOP), irrespective of pause.
- EOP:
  - Increment pkt_cnt, load the gap counter with MIN_GAP, return to IDLE.
  - With MIN_GAP=0, a new desc can be accepted on this edge and wr_sop appears the cycle after the eop cycle.

Pause and back-to-back rules:
- Pause latency is one cycle. A word already on the bus when pause rises is committed; hydra tolerates this.
- wr_sop, wr_vld, and wr_eop are never high together.
- in_rdy is 0 outside PAY.

Optional Feature:
- Macro: FRAMER_TIMEOUT_EN.
- With the macro:
  - In PAY, count consecutive edges with pause=0 and no payload transfer; the counter resets on any transfer.
  - When the count reaches TIMEOUT: set pad_flag, force in_rdy=0, and emit the rem remaining words as 0x0000 (one per pause-free cycle), then EOP as normal.
- Without the macro: no counter exists, pad_flag is tied 0, and PAY waits indefinitely.

Test Plan:
- Basic packet: desc dest=3, prio=4, len=42; payload 1..42 streamed with in_vld always high and pause=0.
  - wr_sop at T+1, header 0x1543 at T+2, words 1..42 at T+3..T+44, wr_eop at T+45.
  - pkt_cnt=1.
- Back-to-back packets: two descriptors, dest=4 then dest=5, each prio=4, len=64, MIN_GAP=0.
  - Headers 0x2044 and 0x2045.
  - Second wr_sop on the cycle immediately after the first wr_eop.
  - pkt_cnt=2, 130 wr_vld cycles total.
- Pause mid-payload: pause high for 5 cycles after word 10 of 42.
  - Exactly one extra word (11) is committed after the pause edge, then wr_vld=0 for the pause window.
  - Words resume in order with no loss or duplication; wr_eop appears 5 cycles late.
- Length errors: desc_len=0, then desc_len=MAX_LEN+1.
  - Each gives a one-cycle len_err, no wr_sop, busy stays 0.
  - A following valid desc proceeds normally.
- Reset mid-packet: rst asserted during PAY at word 20.
  - All outputs are 0 on the next cycle and no wr_eop is emitted.
  - pkt_cnt=0 and desc_rdy=1 after rst drops.
- Timeout pad (FRAMER_TIMEOUT_EN, TIMEOUT=8): len=16, in_vld stops after word 5.
  - After 8 idle cycles, 11 words of 0x0000 are emitted, then wr_eop; pad_flag=1.
